// File: rtl/bp_fe_pkg.sv
// Shared frontend definitions.
//   bp_fe_upd_arb_state_e : state of the predictor-table update arbiter
//     e_reset - first cycle after reset; no table writes are issued
//     e_clear - clear sweep walks every table index
//     e_run   - normal redirect / attaboy update scheduling
package bp_fe_pkg;

    typedef enum logic [1:0] {
        e_reset,
        e_clear,
        e_run
    } bp_fe_upd_arb_state_e;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small one-read one-write FIFO (ready_then_valid input protocol).
//   clk_i/reset_i     : clock, synchronous active-high reset (empties the FIFO)
//   v_i/ready_o/data_i: enqueue side; v_i may only be raised while ready_o=1
//   v_o/data_o/yumi_i : dequeue side; data_o is the head, and yumi_i pops it
// ready_o comes from registered occupancy only, so a full FIFO refuses an
// enqueue even in a cycle where it also dequeues. The FIFO has no bypass path.
module bsg_fifo_1r1w_small #(
    parameter int width_p = 8,
    parameter int els_p   = 4    // power of 2, >= 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    localparam int ptr_w = $clog2(els_p);

    logic [els_p-1:0][width_p-1:0] mem;
    logic [ptr_w-1:0]              rptr, wptr;
    logic [ptr_w:0]                count;
    logic                          enq, deq;

    assign ready_o = (count != (ptr_w+1)'(els_p));
    assign v_o     = (count != '0);
    assign data_o  = mem[rptr];
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;

    // Pointers wrap naturally because els_p is a power of 2.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (enq) wptr <= wptr + 1'b1;
            if (deq) rptr <= rptr + 1'b1;
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) mem[wptr] <= data_i;
    end

endmodule

// File: rtl/bp_fe_pred_update_arb.sv
// Schedules every write into one branch-predictor table write port.
//   clk_i, reset_i            : clock, synchronous active-high reset
//   init_done_o               : post-reset clear sweep has finished
//   redirect_v/data/yumi      : backend redirect updates, highest priority, unbuffered
//   attaboy_v/data/yumi       : correct-prediction updates, accepted into a FIFO
//   flush_i                   : drop all queued attaboys
//   w_v/clr/idx/src/data_o    : table write request (src 1=redirect, 0=attaboy)
//   w_yumi_i                  : table consumed the write
// After reset every table index is written with zeros. Only then are
// updates accepted. A starve counter limits consecutive redirect grants
// while attaboys are waiting.
module bp_fe_pred_update_arb
    import bp_fe_pkg::*;
#(
    parameter int upd_width_p    = 64,
    parameter int idx_width_p    = 9,
    parameter int fifo_els_p     = 4,
    parameter int starve_limit_p = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    output logic                   init_done_o,
    input  logic                   redirect_v_i,
    input  logic [upd_width_p-1:0] redirect_data_i,
    output logic                   redirect_yumi_o,
    input  logic                   attaboy_v_i,
    input  logic [upd_width_p-1:0] attaboy_data_i,
    output logic                   attaboy_yumi_o,
    input  logic                   flush_i,
    output logic                   w_v_o,
    output logic                   w_clr_o,
    output logic [idx_width_p-1:0] w_idx_o,
    output logic                   w_src_o,
    output logic [upd_width_p-1:0] w_data_o,
    input  logic                   w_yumi_i
);
    localparam int                     sc_w       = $clog2(starve_limit_p + 1);
    localparam logic [idx_width_p-1:0] idx_last   = '1;
    localparam logic [sc_w-1:0]        starve_lim = sc_w'(starve_limit_p);

    bp_fe_upd_arb_state_e state_r, state_n;
    logic [idx_width_p-1:0] sweep_r;
    logic [sc_w-1:0]        starve_r;

    logic                   fifo_v, fifo_ready, fifo_deq;
    logic [upd_width_p-1:0] fifo_data;
    logic                   run, redir_gnt;

    assign run = (state_r == e_run);

    // Redirects win unless attaboys have waited through starve_limit_p grants.
    assign redir_gnt = run & redirect_v_i & ~(fifo_v & (starve_r == starve_lim));

    always_comb begin
        state_n         = state_r;
        init_done_o     = run;
        w_v_o           = 1'b0;
        w_clr_o         = 1'b0;
        w_idx_o         = sweep_r;
        w_src_o         = 1'b0;
        w_data_o        = '0;
        redirect_yumi_o = 1'b0;
        attaboy_yumi_o  = 1'b0;
        fifo_deq        = 1'b0;
        case (state_r)
            e_reset: state_n = e_clear;
            e_clear: begin
                w_v_o   = 1'b1;
                w_clr_o = 1'b1;
                if (w_yumi_i && sweep_r == idx_last) state_n = e_run;
            end
            e_run: begin
                attaboy_yumi_o = attaboy_v_i & fifo_ready & ~flush_i;
                if (redir_gnt) begin
                    w_v_o           = 1'b1;
                    w_src_o         = 1'b1;
                    w_data_o        = redirect_data_i;
                    redirect_yumi_o = w_yumi_i;
                end else if (fifo_v) begin
                    w_v_o    = 1'b1;
                    w_data_o = fifo_data;
                    fifo_deq = w_yumi_i;
                end
            end
            default: state_n = e_reset;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= e_reset;
            sweep_r <= '0;
        end else begin
            state_r <= state_n;
            if (state_r == e_clear && w_yumi_i) sweep_r <= sweep_r + 1'b1;
        end
    end

    // Counts redirect grants taken while attaboys wait; any attaboy drain
    // or an empty queue restarts the count.
    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i || !fifo_v || fifo_deq)
            starve_r <= '0;
        else if (redirect_yumi_o && starve_r != starve_lim)
            starve_r <= starve_r + 1'b1;
    end

    // A flush is a reset of the queue; a concurrent dequeue is harmless.
    bsg_fifo_1r1w_small #(
        .width_p(upd_width_p),
        .els_p  (fifo_els_p)
    ) attaboy_fifo (
        .clk_i  (clk_i),
        .reset_i(reset_i | flush_i),
        .v_i    (attaboy_yumi_o),
        .ready_o(fifo_ready),
        .data_i (attaboy_data_i),
        .v_o    (fifo_v),
        .data_o (fifo_data),
        .yumi_i (fifo_deq)
    );

endmodule

// File: tb/tb_bp_fe_pred_update_arb.sv
module tb_bp_fe_pred_update_arb;
    localparam int UW = 16;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          reset_i, redirect_v_i, attaboy_v_i, flush_i, w_yumi_i;
    logic [UW-1:0] redirect_data_i, attaboy_data_i, w_data_o;
    logic          init_done_o, redirect_yumi_o, attaboy_yumi_o;
    logic          w_v_o, w_clr_o, w_src_o;
    logic [IW-1:0] w_idx_o;

    bp_fe_pred_update_arb #(
        .upd_width_p(UW), .idx_width_p(IW), .fifo_els_p(4), .starve_limit_p(8)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .init_done_o(init_done_o),
        .redirect_v_i(redirect_v_i), .redirect_data_i(redirect_data_i),
        .redirect_yumi_o(redirect_yumi_o),
        .attaboy_v_i(attaboy_v_i), .attaboy_data_i(attaboy_data_i),
        .attaboy_yumi_o(attaboy_yumi_o), .flush_i(flush_i),
        .w_v_o(w_v_o), .w_clr_o(w_clr_o), .w_idx_o(w_idx_o), .w_src_o(w_src_o),
        .w_data_o(w_data_o), .w_yumi_i(w_yumi_i)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    logic [UW-1:0] sb[$];   // expected attaboy writes, in order

    typedef struct packed {
        logic rv, av, wy, fl;      // inputs
        logic ewv, esrc, ery, eay; // expected outputs
    } vec_t;
    vec_t tbl [31];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, rv, av, wy, fl,
                         input logic [UW-1:0] rd, ad);
        reset_i = rst; redirect_v_i = rv; attaboy_v_i = av;
        w_yumi_i = wy; flush_i = fl;
        redirect_data_i = rd; attaboy_data_i = ad;
    endtask

    // Mid-cycle sample; pops the scoreboard on every consumed attaboy write.
    task automatic settle;
        @(negedge clk);
        if (!reset_i && w_v_o && w_yumi_i && !w_clr_o && !w_src_o) begin
            if (sb.size() == 0) chk("sb_underflow", 64'(w_data_o), 64'hDEAD);
            else chk("atb_data", 64'(w_data_o), 64'(sb.pop_front()));
        end
    endtask

    task automatic adv;
        @(posedge clk);
        #1;
    endtask

    // Hold reset for n cycles, then check the e_reset cycle with traffic offered.
    task automatic do_reset(input int n);
        drive(1, 0, 0, 1, 0, '0, '0);
        repeat (n) adv();
        sb.delete();
        drive(0, 1, 1, 1, 0, 16'h1111, 16'h2222);
        settle();
        chk("rst_init_done", 64'(init_done_o), 0);
        chk("rst_w_v", 64'(w_v_o), 0);
        chk("rst_ryumi", 64'(redirect_yumi_o), 0);
        chk("rst_ayumi", 64'(attaboy_yumi_o), 0);
        adv();
    endtask

    // Sweep cycles idx 0..last with w_yumi_i held and traffic offered.
    task automatic sweep(input int last);
        for (int i = 0; i <= last; i++) begin
            drive(0, 1, 1, 1, 0, 16'h1111, 16'h2222);
            settle();
            chk("swp_w_v", 64'(w_v_o), 1);
            chk("swp_clr", 64'(w_clr_o), 1);
            chk("swp_idx", 64'(w_idx_o), 64'(i));
            chk("swp_data", 64'(w_data_o), 0);
            chk("swp_init_done", 64'(init_done_o), 0);
            chk("swp_ryumi", 64'(redirect_yumi_o), 0);
            chk("swp_ayumi", 64'(attaboy_yumi_o), 0);
            if (i != last) adv();
        end
    endtask

    initial begin
        // rv av wy fl | ewv esrc ery eay
        tbl = '{
            8'b0100_0001, 8'b0100_1001, 8'b0100_1001, 8'b0100_1001, // fill 4
            8'b0100_1000,                                           // full: held
            8'b0010_1000, 8'b0010_1000, 8'b0010_1000, 8'b0010_1000, // drain
            8'b0010_0000,
            8'b0100_0001, 8'b1010_1110, 8'b0010_1000, 8'b0010_0000, // redirect first
            8'b0100_0001, 8'b0000_1000, 8'b1000_1100, 8'b0010_1000, // preemption
            8'b0100_0001, 8'b0100_1001, 8'b0100_1001, 8'b0100_1001, // refill
            8'b0110_1000,                                           // full + deq
            8'b0100_1001, 8'b0010_1000,
            8'b0101_1000, 8'b0010_0000,                             // flush with 3
            8'b0100_0001, 8'b0011_1000, 8'b0010_0000,               // deq + flush
            8'b1011_1110                                            // redirect in flush
        };

        drive(1, 0, 0, 0, 0, '0, '0);
        adv();
        do_reset(2);
        sweep(7);
        adv();
        drive(0, 0, 0, 0, 0, '0, '0);
        settle();
        chk("init_done_rise", 64'(init_done_o), 1);
        chk("run_idle_w_v", 64'(w_v_o), 0);
        chk("run_clr", 64'(w_clr_o), 0);
        adv();

        for (int r = 0; r < 31; r++) begin
            logic [UW-1:0] rd, ad;
            rd = 16'hB000 | UW'(r);
            ad = 16'hA000 | UW'(r);
            drive(0, tbl[r].rv, tbl[r].av, tbl[r].wy, tbl[r].fl, rd, ad);
            settle();
            chk($sformatf("t%0d_w_v", r), 64'(w_v_o), 64'(tbl[r].ewv));
            if (tbl[r].ewv) chk($sformatf("t%0d_src", r), 64'(w_src_o), 64'(tbl[r].esrc));
            if (tbl[r].ewv && tbl[r].esrc) chk($sformatf("t%0d_rdata", r), 64'(w_data_o), 64'(rd));
            chk($sformatf("t%0d_ryumi", r), 64'(redirect_yumi_o), 64'(tbl[r].ery));
            chk($sformatf("t%0d_ayumi", r), 64'(attaboy_yumi_o), 64'(tbl[r].eay));
            if (tbl[r].eay) sb.push_back(ad);
            if (tbl[r].fl) sb.delete();
            adv();
        end
        chk("sb_empty_after_tbl", 64'(sb.size()), 0);

        // Starvation: 2 queued attaboys under 20 cycles of redirects.
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 1, 0, 0, '0, 16'hE000 | UW'(i));
            settle();
            chk("stv_ayumi", 64'(attaboy_yumi_o), 1);
            sb.push_back(16'hE000 | UW'(i));
            adv();
        end
        for (int k = 1; k <= 20; k++) begin
            logic es;
            es = !(k == 9 || k == 18);
            drive(0, 1, 0, 1, 0, 16'hC000 | UW'(k), '0);
            settle();
            chk($sformatf("stv%0d_w_v", k), 64'(w_v_o), 1);
            chk($sformatf("stv%0d_src", k), 64'(w_src_o), 64'(es));
            chk($sformatf("stv%0d_ryumi", k), 64'(redirect_yumi_o), 64'(es));
            if (es) chk($sformatf("stv%0d_rdata", k), 64'(w_data_o), 64'(16'hC000 | UW'(k)));
            adv();
        end
        chk("sb_empty_after_stv", 64'(sb.size()), 0);

        // Queue two entries, then reset; pulse reset again at sweep idx 5.
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 1, 0, 0, '0, 16'hF000 | UW'(i));
            settle();
            chk("pre_rst_ayumi", 64'(attaboy_yumi_o), 1);
            adv();
        end
        do_reset(1);
        sweep(5);
        adv();
        do_reset(1);
        sweep(7);
        adv();
        drive(0, 0, 0, 1, 0, '0, '0);
        settle();
        chk("rst2_init_done", 64'(init_done_o), 1);
        chk("rst2_fifo_empty", 64'(w_v_o), 0);
        adv();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
